// File: rtl/display_scan_ctrl.sv
// Basys2 4-digit seven-segment scan controller. It multiplexes clock or stopwatch digits
// with per-digit blink and a timed new-day overlay. Define DISPLAY_LEADING_ZERO_BLANK_EN to suppress a leading clock zero.
module display_scan_ctrl #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_TICKS   = 250,
    parameter int OVERLAY_TICKS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_sel,
    input  logic [3:0] clk_d1,
    input  logic [3:0] clk_d2,
    input  logic [3:0] clk_d3,
    input  logic [3:0] clk_d4,
    input  logic [3:0] sw_d1,
    input  logic [3:0] sw_d2,
    input  logic [3:0] sw_d3,
    input  logic [3:0] sw_d4,
    input  logic [3:0] blink,
    input  logic       new_day,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       overlay_active
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = $clog2(BLINK_TICKS + 1);
    localparam int OVL_W = $clog2(OVERLAY_TICKS + 1);

    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_OVERLAY = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [PRE_W-1:0] prescaleCnt;
    logic             scanTick;
    logic [1:0]       digitIdx;
    logic [BLK_W-1:0] blinkCnt;
    logic             blinkPhase;
    logic [0:0]       state;
    logic [OVL_W-1:0] overlayCnt;
    logic             overlayOn;
    logic             snapMode;
    logic [3:0]       snapDigit [4];
    logic [3:0]       snapBlink;
    logic             useClock;
    logic [3:0]       curDigit;
    logic             blankNow;
    logic [6:0]       segNext;
    logic             dpNext;

    function automatic logic [6:0] decodeSeg(input logic [3:0] value);
        case (value)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign scanTick       = (prescaleCnt == PRE_W'(SCAN_DIV - 1));
    assign overlayOn      = (state == ST_OVERLAY);
    assign overlay_active = overlayOn;
    assign useClock       = overlayOn | mode_sel;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaleCnt <= '0;
        end else if (scanTick) begin
            prescaleCnt <= '0;
        end else begin
            prescaleCnt <= prescaleCnt + 1'b1;
        end
    end

    // The blink counter free-runs on scan ticks so phase is independent of frames and overlay.
    always_ff @(posedge clk) begin
        if (rst) begin
            digitIdx   <= 2'd0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (scanTick) begin
            digitIdx <= digitIdx + 2'd1;
            if (blinkCnt == BLK_W'(BLINK_TICKS - 1)) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
        end
    end

    // A new_day pulse takes priority, so a reload coinciding with expiry keeps the overlay running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            overlayCnt <= '0;
        end else if (new_day) begin
            state      <= ST_OVERLAY;
            overlayCnt <= OVL_W'(OVERLAY_TICKS);
        end else if (overlayOn && scanTick) begin
            if (overlayCnt <= OVL_W'(1)) begin
                state      <= ST_NORMAL;
                overlayCnt <= '0;
            end else begin
                overlayCnt <= overlayCnt - 1'b1;
            end
        end
    end

    // NOTE: the snapshot array is small and must read as zeros before the first frame, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapMode  <= 1'b1;
            snapBlink <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                snapDigit[i] <= 4'd0;
            end
        end else if (scanTick && digitIdx == 2'd3) begin
            snapMode     <= useClock;
            snapBlink    <= blink;
            snapDigit[3] <= useClock ? clk_d1 : sw_d1;
            snapDigit[2] <= useClock ? clk_d2 : sw_d2;
            snapDigit[1] <= useClock ? clk_d3 : sw_d3;
            snapDigit[0] <= useClock ? clk_d4 : sw_d4;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        curDigit = snapDigit[digitIdx];
        blankNow = blinkPhase && (overlayOn || snapBlink[digitIdx]);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (snapMode && digitIdx == 2'd3 && curDigit == 4'd0) begin
            blankNow = 1'b1;
        end
`endif
        segNext = blankNow ? SEG_BLANK : decodeSeg(curDigit);
        if (overlayOn) begin
            dpNext = blinkPhase;
        end else begin
            dpNext = !(digitIdx == 2'd2 && snapMode && !blinkPhase);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (scanTick) begin
            an  <= ~(4'b0001 << digitIdx);
            seg <= segNext;
            dp  <= dpNext;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4, BLINK_TICKS=8, OVERLAY_TICKS=32.
// Scan tick t lands on clk edge 4t after reset release and shows digit index (t-1)%4.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV      = 4;
    localparam int BLINK_TICKS   = 8;
    localparam int OVERLAY_TICKS = 32;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] CLK_D1_ZERO = SEG_BLANK;
`else
    localparam logic [6:0] CLK_D1_ZERO = SEG_0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_sel;
    logic [3:0] clk_d1, clk_d2, clk_d3, clk_d4;
    logic [3:0] sw_d1, sw_d2, sw_d3, sw_d4;
    logic [3:0] blink;
    logic       new_day;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       overlay_active;

    int vectors     = 0;
    int miscompares = 0;
    int posCnt      = 0;

    display_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_TICKS  (BLINK_TICKS),
        .OVERLAY_TICKS(OVERLAY_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_sel      (mode_sel),
        .clk_d1        (clk_d1),
        .clk_d2        (clk_d2),
        .clk_d3        (clk_d3),
        .clk_d4        (clk_d4),
        .sw_d1         (sw_d1),
        .sw_d2         (sw_d2),
        .sw_d3         (sw_d3),
        .sw_d4         (sw_d4),
        .blink         (blink),
        .new_day       (new_day),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .overlay_active(overlay_active)
    );

    always #5 clk = ~clk;

    // Edge count since reset release, the time base all expected values are keyed to.
    always @(posedge clk) begin
        if (rst) posCnt <= 0;
        else     posCnt <= posCnt + 1;
    end

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic go_cyc(input int target);
        int guard = 0;
        while (posCnt < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (posCnt < target) begin
            miscompares++;
            $display("FAIL timeout waiting for edge %0d (at %0d)", target, posCnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        mode_sel = 1'b1;
        clk_d1 = 4'd1; clk_d2 = 4'd2; clk_d3 = 4'd3; clk_d4 = 4'd4;
        sw_d1  = 4'd5; sw_d2  = 4'd6; sw_d3  = 4'd7; sw_d4  = 4'd8;
        blink    = 4'b0000;
        new_day  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, SEG_BLANK);
        check("rst_dp", dp, 1'b1);
        check("rst_ovl", overlay_active, 1'b0);
        rst = 1'b0;

        // Frame 0 shows the reset snapshot: all zeros, clock mode.
        go_cyc(3);   check("pre_tick_an", an, 4'b1111); check("pre_tick_seg", seg, SEG_BLANK);
        go_cyc(4);   check("t1_an", an, 4'b1110); check("t1_seg", seg, SEG_0); check("t1_dp", dp, 1'b1);
        go_cyc(7);   check("t1_hold_an", an, 4'b1110);
        go_cyc(8);   check("t2_an", an, 4'b1101);
        go_cyc(12);  check("t3_an", an, 4'b1011); check("t3_dp", dp, 1'b0);
        go_cyc(16);  check("t4_an", an, 4'b0111); check("t4_seg", seg, CLK_D1_ZERO); check("t4_dp", dp, 1'b1);

        // Frame 1: clock digits 1,2,3,4.
        go_cyc(20);  check("t5_an", an, 4'b1110); check("t5_seg", seg, SEG_4); check("t5_dp", dp, 1'b1);
        go_cyc(24);  check("t6_seg", seg, SEG_3);
        go_cyc(28);  check("t7_an", an, 4'b1011); check("t7_seg", seg, SEG_2); check("t7_dp", dp, 1'b0);
        go_cyc(32);  check("t8_an", an, 4'b0111); check("t8_seg", seg, SEG_1);

        // Mid-frame switch to stopwatch: current frame finishes on clock digits.
        go_cyc(36);  check("t9_seg", seg, SEG_4); check("t9_dp_phase1", dp, 1'b1);
        mode_sel = 1'b0;
        go_cyc(40);  check("t10_seg_clk", seg, SEG_3);
        go_cyc(48);  check("t12_seg_clk", seg, SEG_1);
        go_cyc(52);  check("t13_seg_sw", seg, SEG_8);
        go_cyc(56);  check("t14_seg_sw", seg, SEG_7);
        go_cyc(64);  check("t16_seg_sw", seg, SEG_5);
        go_cyc(68);  check("t17_seg_sw", seg, SEG_8);
        blink = 4'b1100;
        go_cyc(76);  check("t19_an", an, 4'b1011); check("t19_seg", seg, SEG_6); check("t19_dp_sw", dp, 1'b1);

        // Blink 1100: phase 0 visible, phase 1 blanks d1/d2 only.
        go_cyc(96);  check("t24_blink_ph0", seg, SEG_5);
        go_cyc(100); check("t25_an", an, 4'b1110); check("t25_steady", seg, SEG_8);
        sw_d3 = 4'd12; sw_d1 = 4'd0; blink = 4'b0000;
        go_cyc(108); check("t27_an", an, 4'b1011); check("t27_blank", seg, SEG_BLANK);
        go_cyc(112); check("t28_an", an, 4'b0111); check("t28_blank", seg, SEG_BLANK);

        // Value 12 blanks; stopwatch leading zero is always shown.
        go_cyc(116); check("t29_seg", seg, SEG_8);
        go_cyc(120); check("t30_val12", seg, SEG_BLANK);
        go_cyc(124); check("t31_seg", seg, SEG_6);
        mode_sel = 1'b1; clk_d1 = 4'd0;
        go_cyc(128); check("t32_sw_zero", seg, SEG_0);
        go_cyc(140); check("t35_seg", seg, SEG_2); check("t35_dp", dp, 1'b0);
        go_cyc(144); check("t36_clk_zero", seg, CLK_D1_ZERO);

        // Overlay: forced clock source, all digits blink, dp low on all in phase 0.
        go_cyc(150); check("ovl_before", overlay_active, 1'b0);
        new_day = 1'b1; mode_sel = 1'b0; clk_d1 = 4'd1;
        go_cyc(151); check("ovl_start", overlay_active, 1'b1);
        new_day = 1'b0;
        go_cyc(164); check("t41_an", an, 4'b1110); check("t41_blank", seg, SEG_BLANK); check("t41_dp", dp, 1'b1);
        go_cyc(172); check("t43_blank", seg, SEG_BLANK);
        go_cyc(196); check("t49_an", an, 4'b1110); check("t49_seg", seg, SEG_4); check("t49_dp", dp, 1'b0);
        go_cyc(200); check("t50_seg", seg, SEG_3); check("t50_dp", dp, 1'b0);
        go_cyc(208); check("t52_an", an, 4'b0111); check("t52_seg", seg, SEG_1); check("t52_dp", dp, 1'b0);

        // Second pulse 20 ticks in restarts the 32-tick run.
        go_cyc(229); new_day = 1'b1;
        go_cyc(230); new_day = 1'b0; check("ovl_reload", overlay_active, 1'b1);
        go_cyc(280); check("ovl_extended", overlay_active, 1'b1);
        go_cyc(355); check("ovl_last", overlay_active, 1'b1);
        go_cyc(356); check("ovl_end", overlay_active, 1'b0);

        // Third overlay, with a pulse landing on the expiring tick.
        go_cyc(360); new_day = 1'b1;
        go_cyc(361); new_day = 1'b0; check("ovl3_start", overlay_active, 1'b1);
        go_cyc(487); new_day = 1'b1;
        go_cyc(488); new_day = 1'b0; check("ovl_collide", overlay_active, 1'b1);
        go_cyc(500); check("ovl_collide_hold", overlay_active, 1'b1);

        // Reset mid-overlay and mid-frame.
        go_cyc(502); rst = 1'b1;
        @(negedge clk);
        check("rst2_an", an, 4'b1111);
        check("rst2_seg", seg, SEG_BLANK);
        check("rst2_dp", dp, 1'b1);
        check("rst2_ovl", overlay_active, 1'b0);
        rst = 1'b0;
        go_cyc(3);   check("rst2_pre_an", an, 4'b1111);
        go_cyc(4);   check("rst2_t1_an", an, 4'b1110); check("rst2_t1_seg", seg, SEG_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
